// File: rtl/uart_pkg.sv
// Shared types and helpers for the extended UART receiver.
// The state enum, parity mode codes and the 3-sample majority vote live here.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-flop synchroniser for the asynchronous rx pin.
// Resets to 1 so that the line looks idle while reset is applied.
module uart_sync
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw pin through the flop chain
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= {SYNC_STAGES{1'b1}};
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ext.sv
// Parametrised UART receiver: majority-voted bit sampling, optional parity,
// 1 or 2 stop bits, and a valid/ready output register with error reporting.
module uart_rx_ext
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_PULSE = 5208,
  parameter int BITS_PER_WORD    = 8,
  parameter int PARITY_MODE      = 0,
  parameter int STOP_BITS        = 1,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     rx,
  input  logic                     m_ready,
  output logic                     m_valid,
  output logic [BITS_PER_WORD-1:0] m_data,
  output logic                     m_parity_err,
  output logic                     m_frame_err,
  output logic                     m_overrun
);

  localparam int HALF = CLOCKS_PER_PULSE / 2;
  localparam int CW   = $clog2(CLOCKS_PER_PULSE);
  localparam int BW   = ($clog2(BITS_PER_WORD) > 0) ? $clog2(BITS_PER_WORD) : 1;

  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_MID  = CW'(HALF + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BITS_PER_WORD - 1);
  localparam logic [BW-1:0] S_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD_EXPECT = (PARITY_MODE == PARITY_ODD) ? 1'b1 : 1'b0;

  logic                     rxs;
  rx_state_t                state, state_nx;
  logic [CW-1:0]            c_clocks, c_clocks_nx;
  logic [BW-1:0]            c_bits, c_bits_nx;
  logic [BITS_PER_WORD-1:0] shift_reg, shift_nx;
  logic [1:0]               samp, samp_nx;
  logic                     par_err, par_err_nx;
  logic                     frm_err, frm_err_nx;
  logic                     commit;
  logic                     maj;
  logic                     at_mid;
  logic                     period_end;

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx),
    .q    (rxs)
  );

  assign maj        = majority3(samp[0], samp[1], rxs);
  assign at_mid     = (c_clocks == C_MID);
  assign period_end = (c_clocks == C_LAST);

  // Frame state and datapath registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      c_clocks  <= {CW{1'b0}};
      c_bits    <= {BW{1'b0}};
      shift_reg <= {BITS_PER_WORD{1'b0}};
      samp      <= 2'b00;
      par_err   <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      state     <= state_nx;
      c_clocks  <= c_clocks_nx;
      c_bits    <= c_bits_nx;
      shift_reg <= shift_nx;
      samp      <= samp_nx;
      par_err   <= par_err_nx;
      frm_err   <= frm_err_nx;
    end
  end

  // Next-state, bit timing and per-frame capture
  always_comb begin
    state_nx    = state;
    c_clocks_nx = period_end ? {CW{1'b0}} : c_clocks + CW'(1);
    c_bits_nx   = c_bits;
    shift_nx    = shift_reg;
    samp_nx     = samp;
    par_err_nx  = par_err;
    frm_err_nx  = frm_err;
    commit      = 1'b0;

    if (c_clocks == C_S0) begin
      samp_nx[0] = rxs;
    end else begin
      samp_nx[0] = samp[0];
    end
    if (c_clocks == C_S1) begin
      samp_nx[1] = rxs;
    end else begin
      samp_nx[1] = samp[1];
    end

    case (state)
      IDLE: begin
        c_clocks_nx = {CW{1'b0}};
        c_bits_nx   = {BW{1'b0}};
        if (!rxs) begin
          state_nx   = START;
          par_err_nx = 1'b0;
          frm_err_nx = 1'b0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (at_mid && maj) begin
          state_nx    = IDLE;
          c_clocks_nx = {CW{1'b0}};
        end else if (period_end) begin
          state_nx  = DATA;
          c_bits_nx = {BW{1'b0}};
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (at_mid) begin
          shift_nx = {maj, shift_reg[BITS_PER_WORD-1:1]};
        end else begin
          shift_nx = shift_reg;
        end
        if (period_end && (c_bits == B_LAST)) begin
          state_nx  = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
          c_bits_nx = {BW{1'b0}};
        end else if (period_end) begin
          c_bits_nx = c_bits + BW'(1);
        end else begin
          c_bits_nx = c_bits;
        end
      end
      PARITY: begin
        if (at_mid) begin
          par_err_nx = ((^shift_reg) ^ maj) != ODD_EXPECT;
        end else begin
          par_err_nx = par_err;
        end
        if (period_end) begin
          state_nx  = STOP;
          c_bits_nx = {BW{1'b0}};
        end else begin
          state_nx = PARITY;
        end
      end
      STOP: begin
        if (at_mid && !maj) begin
          frm_err_nx = 1'b1;
        end else begin
          frm_err_nx = frm_err;
        end
        // Commit mid-way through the last stop bit to leave resync margin
        if (at_mid && (c_bits == S_LAST)) begin
          commit      = 1'b1;
          state_nx    = IDLE;
          c_clocks_nx = {CW{1'b0}};
        end else if (period_end) begin
          c_bits_nx = c_bits + BW'(1);
        end else begin
          state_nx = STOP;
        end
      end
      default: begin
        state_nx    = IDLE;
        c_clocks_nx = {CW{1'b0}};
      end
    endcase
  end

  // Output register with valid/ready handshake and overrun pulse
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid      <= 1'b0;
      m_data       <= {BITS_PER_WORD{1'b0}};
      m_parity_err <= 1'b0;
      m_frame_err  <= 1'b0;
      m_overrun    <= 1'b0;
    end else begin
      m_overrun <= 1'b0;
      if (commit && (!m_valid || m_ready)) begin
        m_valid      <= 1'b1;
        m_data       <= shift_reg;
        m_parity_err <= par_err;
        m_frame_err  <= frm_err_nx;
      end else if (commit) begin
        m_overrun <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end else begin
        m_valid <= m_valid;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ext.sv
// Randomised and directed bench for uart_rx_ext with a frame-level reference model.
// Three receivers (no parity/1 stop, even/1 stop, odd/2 stop) share clock and reset.
module tb_uart_rx_ext;

  localparam int CPP  = 16;
  localparam int HALF = CPP / 2;
  localparam int NL   = 3;

  typedef struct {
    int         lane;
    int         cyc;
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } commit_t;

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       rx   [NL];
  logic       rdy  [NL];
  logic       mv   [NL];
  logic [7:0] md   [NL];
  logic       mpe  [NL];
  logic       mfe  [NL];
  logic       movr [NL];

  logic       e_mv  [NL];
  logic [7:0] e_md  [NL];
  logic       e_pe  [NL];
  logic       e_fe  [NL];
  logic       e_ovr [NL];
  commit_t    pend[$];

  int cyc      = 0;
  int tests    = 0;
  int fails    = 0;
  int ovr_cnt0 = 0;
  bit rand_on  = 1'b0;

  always #5 clk = ~clk;

  uart_rx_ext #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .rstn(rstn), .rx(rx[0]), .m_ready(rdy[0]), .m_valid(mv[0]), .m_data(md[0]),
    .m_parity_err(mpe[0]), .m_frame_err(mfe[0]), .m_overrun(movr[0]));
  uart_rx_ext #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .rstn(rstn), .rx(rx[1]), .m_ready(rdy[1]), .m_valid(mv[1]), .m_data(md[1]),
    .m_parity_err(mpe[1]), .m_frame_err(mfe[1]), .m_overrun(movr[1]));
  uart_rx_ext #(.CLOCKS_PER_PULSE(CPP), .BITS_PER_WORD(8), .PARITY_MODE(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .rstn(rstn), .rx(rx[2]), .m_ready(rdy[2]), .m_valid(mv[2]), .m_data(md[2]),
    .m_parity_err(mpe[2]), .m_frame_err(mfe[2]), .m_overrun(movr[2]));

  function automatic int pm_of(input int l);
    case (l)
      1:       return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int sb_of(input int l);
    return (l == 2) ? 2 : 1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Model: a word lands SYNC(2)+3 cycles after the line falls plus the last stop-bit vote point
  task automatic model_loop();
    forever begin
      @(posedge clk);
      cyc++;
      for (int l = 0; l < NL; l++) begin
        bit      hit;
        commit_t c;
        hit      = 1'b0;
        e_ovr[l] = 1'b0;
        foreach (pend[k]) begin
          if (pend[k].lane == l && pend[k].cyc == cyc) begin
            hit = 1'b1;
            c   = pend[k];
          end
        end
        if (!rstn) begin
          e_mv[l] = 1'b0; e_md[l] = 8'h00; e_pe[l] = 1'b0; e_fe[l] = 1'b0;
        end else if (hit && (!e_mv[l] || rdy[l])) begin
          e_mv[l] = 1'b1; e_md[l] = c.d; e_pe[l] = c.pe; e_fe[l] = c.fe;
        end else if (hit) begin
          e_ovr[l] = 1'b1;
        end else if (e_mv[l] && rdy[l]) begin
          e_mv[l] = 1'b0;
        end
      end
      if (!rstn) pend.delete();
      for (int k = pend.size() - 1; k >= 0; k--) begin
        if (pend[k].cyc <= cyc) pend.delete(k);
      end
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        tests++;
        if (movr[l] === 1'b1 && l == 0) ovr_cnt0++;
        if (mv[l] !== e_mv[l] || movr[l] !== e_ovr[l] ||
            (e_mv[l] && (md[l] !== e_md[l] || mpe[l] !== e_pe[l] || mfe[l] !== e_fe[l]))) begin
          fails++;
          $display("FAIL cycle lane%0d @%0d: got v=%b d=%h pe=%b fe=%b ovr=%b, expected v=%b d=%h pe=%b fe=%b ovr=%b",
                   l, cyc, mv[l], md[l], mpe[l], mfe[l], movr[l], e_mv[l], e_md[l], e_pe[l], e_fe[l], e_ovr[l]);
        end
      end
    end
  endtask

  // par < 0 sends the correct parity bit; glitch_bit / abort_bit index frame bits (0 = start)
  task automatic send_frame(input int lane, input logic [7:0] d, input int par, input logic stop_last,
                            input int glitch_bit, input int abort_bit, input int gap);
    logic    bits[$];
    logic    good_p, pbit;
    commit_t c;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    good_p = (pm_of(lane) == 1) ? ^d : ~^d;
    pbit   = (par < 0) ? good_p : par[0];
    if (pm_of(lane) != 0) bits.push_back(pbit);
    for (int i = 1; i < sb_of(lane); i++) bits.push_back(1'b1);
    bits.push_back(stop_last);
    @(negedge clk);
    c.lane = lane;
    c.cyc  = cyc + 5 + (bits.size() - 1) * CPP + HALF;
    c.d    = d;
    c.pe   = (pm_of(lane) != 0) && (pbit != good_p);
    c.fe   = ~stop_last;
    pend.push_back(c);
    for (int i = 0; i < bits.size(); i++) begin
      rx[lane] = bits[i];
      for (int j = 0; j < CPP; j++) begin
        if (i == glitch_bit && j == HALF + 1) rx[lane] = 1'b0;
        if (i == glitch_bit && j == HALF + 2) rx[lane] = bits[i];
        if (i == abort_bit && j == HALF) begin
          rx[lane] = 1'b1;
          #2 rstn = 1'b0;
          repeat (3) @(negedge clk);
          #2 rstn = 1'b1;
          repeat (2 * CPP) @(negedge clk);
          return;
        end
        @(negedge clk);
      end
    end
    rx[lane] = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic accept(input int lane);
    rdy[lane] = 1'b1;
    @(negedge clk);
    rdy[lane] = 1'b0;
  endtask

  initial begin
    int base;
    for (int l = 0; l < NL; l++) begin
      rx[l] = 1'b1; rdy[l] = 1'b0;
    end
    fork
      model_loop();
      compare_loop();
    join_none
    repeat (4) @(negedge clk);
    check("reset_valid", {29'd0, mv[0], mv[1], mv[2]}, 32'd0);
    #2 rstn = 1'b1;
    repeat (3) @(negedge clk);

    // 1: plain 0x55, held until accepted
    send_frame(0, 8'h55, -1, 1'b1, -1, -1, 2 * CPP);
    check("t1_data", {24'd0, md[0]}, 32'h55);
    check("t1_flags", {30'd0, mpe[0], mfe[0]}, 32'd0);
    repeat (5) @(negedge clk);
    check("t1_held", {31'd0, mv[0]}, 32'd1);
    accept(0);
    check("t1_accepted", {31'd0, mv[0]}, 32'd0);

    // 2: even parity, wrong then right
    send_frame(1, 8'hA3, 1, 1'b1, -1, -1, 2 * CPP);
    check("t2_data", {24'd0, md[1]}, 32'hA3);
    check("t2_bad_parity", {31'd0, mpe[1]}, 32'd1);
    accept(1);
    send_frame(1, 8'hA3, 0, 1'b1, -1, -1, 2 * CPP);
    check("t2_good_parity", {31'd0, mpe[1]}, 32'd0);
    accept(1);

    // 3: two stop bits, second one low then high
    send_frame(2, 8'h3C, -1, 1'b0, -1, -1, 2 * CPP);
    check("t3_data", {24'd0, md[2]}, 32'h3C);
    check("t3_frame_err", {31'd0, mfe[2]}, 32'd1);
    accept(2);
    send_frame(2, 8'h3C, -1, 1'b1, -1, -1, 2 * CPP);
    check("t3_frame_ok", {30'd0, mfe[2], mpe[2]}, 32'd0);
    accept(2);

    // 4: false start, then a sample glitch inside data bit 2
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    repeat (3 * CPP) @(negedge clk);
    check("t4_false_start", {31'd0, mv[0]}, 32'd0);
    send_frame(0, 8'hFF, -1, 1'b1, 3, -1, 2 * CPP);
    check("t4_glitch_data", {24'd0, md[0]}, 32'hFF);
    accept(0);

    // 5: overrun with m_ready held low
    base = ovr_cnt0;
    send_frame(0, 8'h11, -1, 1'b1, -1, -1, 0);
    send_frame(0, 8'h22, -1, 1'b1, -1, -1, 4);
    check("t5_held_data", {24'd0, md[0]}, 32'h11);
    check("t5_overruns", ovr_cnt0 - base, 32'd1);
    accept(0);
    check("t5_drained", {31'd0, mv[0]}, 32'd0);

    // 6: reset during data bit 4, then a clean frame
    send_frame(0, 8'h99, -1, 1'b1, -1, 5, 0);
    check("t6_no_output", {29'd0, mv[0], mv[1], mv[2]}, 32'd0);
    send_frame(0, 8'h42, -1, 1'b1, -1, -1, 2 * CPP);
    check("t6_data", {24'd0, md[0]}, 32'h42);
    check("t6_flags", {30'd0, mpe[0], mfe[0]}, 32'd0);
    accept(0);

    // Randomised frames with random back-pressure
    rand_on = 1'b1;
    fork
      while (rand_on) begin
        @(negedge clk);
        for (int l = 0; l < NL; l++) rdy[l] = 1'($urandom_range(0, 1));
      end
    join_none
    for (int n = 0; n < 40; n++) begin
      int   lane, par, glitch, gap;
      logic stop;
      lane   = $urandom_range(0, NL - 1);
      par    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1)) : -1;
      stop   = ($urandom_range(0, 4) != 0);
      glitch = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 9)) : -1;
      gap    = stop ? int'($urandom_range(0, CPP)) : 2 * CPP;
      send_frame(lane, 8'($urandom), par, stop, glitch, -1, gap);
    end
    rand_on = 1'b0;
    repeat (2) @(negedge clk);
    for (int l = 0; l < NL; l++) rdy[l] = 1'b1;
    repeat (4) @(negedge clk);
    check("final_drained", {29'd0, mv[0], mv[1], mv[2]}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_rx_ext.md
Name: uart_rx_ext

Overview:
Parametrised UART receiver and successor to the basic 8N1 receiver.
- Configurable word length, parity (none/even/odd) and 1 or 2 stop bits.
- Input synchroniser, 3-sample majority vote per bit, false-start rejection.
- Valid/ready output register with parity-error, framing-error and overrun reporting.
- Sits between the board RX pin and the byte-stream consumer (FIFO or command parser).

Parameters:
- CLOCKS_PER_PULSE, 5208: clock cycles per bit period. Must be >= 4.
- BITS_PER_WORD, 8: data bits per frame, 5..9, sent LSB first.
- PARITY_MODE, 0: 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1: number of stop bits, 1 or 2.
- SYNC_STAGES, 2: flops in the rx synchroniser, >= 2.

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- rx  in  1  serial input, asynchronous to clk, idles high
- m_ready  in  1  consumer accepts the word when m_valid && m_ready
- m_valid  out  1  output word available
- m_data  out  BITS_PER_WORD  received word
- m_parity_err  out  1  parity mismatch for m_data; 0 when PARITY_MODE = 0
- m_frame_err  out  1  at least one stop bit sampled as 0
- m_overrun  out  1  one-cycle pulse: a completed word was dropped

Behaviour:
Reset and input path:
- Reset is asynchronous and active-low. All outputs reset to 0, state = IDLE, counters = 0.
- Synchroniser flops reset to 1 (line idle). rxs is the synchronised rx.
- Reset mid-frame aborts the frame. Nothing is output afterwards.

Bit timing and majority vote:
- HALF = CLOCKS_PER_PULSE/2.
- c_clocks runs 0..CLOCKS_PER_PULSE-1 within each bit period and returns to 0 at the period end.
- rxs is sampled at c_clocks = HALF-1, HALF and HALF+1. The bit value is the majority of the three samples, decided in the HALF+1 cycle.

State machine (IDLE, START, DATA, PARITY, STOP):
- IDLE: when rxs == 0, go to START with c_clocks = 0.
- START: if the majority is 1, this is a false start; return to IDLE immediately and output nothing. Otherwise, at the period end go to DATA with c_bits = 0.
- DATA: shift the majority bit into the MSB of shift_reg (LSB-first reception). At the period end of bit BITS_PER_WORD-1, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY: capture the majority bit. Error flag = (XOR of data bits XOR parity bit) != expected, where expected is 0 for even and 1 for odd. At the period end go to STOP.
- STOP: capture each stop-bit majority; any 0 sets the frame-error flag. At the HALF+1 cycle of the last stop bit, commit the word and go to IDLE. No wait for the period end, which gives half a bit of resync margin.

Commit and output handshake:
- Latency: m_valid rises the cycle after the last stop-bit majority cycle.
- If m_valid is 0, or m_valid && m_ready in that same cycle: load m_data and both error flags, and set m_valid = 1.
- If m_valid && !m_ready: the new word is dropped, the held word is unchanged, and m_overrun pulses 1 for one cycle.
- m_valid clears on m_valid && m_ready when no commit happens in that cycle.
- A frame with a framing or parity error is still delivered, with its flags set.

Width rules:
- c_clocks width = $clog2(CLOCKS_PER_PULSE).
- c_bits width = $clog2(BITS_PER_WORD), minimum 1.
- Comparisons use constants of matching width. No counter wraps past its terminal value.

Decomposition:
- Package uart_pkg holds:
  - rx_state_t enum {IDLE, START, DATA, PARITY, STOP}, 3 bits
  - PARITY_NONE/EVEN/ODD localparams
  - function majority3
- One sub-module, uart_sync: SYNC_STAGES-deep flop chain, asynchronous active-low reset to 1.

Test Plan:
All scenarios use CLOCKS_PER_PULSE = 16 and BITS_PER_WORD = 8 unless stated.
1. PARITY_MODE 0, STOP_BITS 1; send 0x55 -> m_valid = 1 with m_data = 0x55, both error flags 0, m_valid high until m_ready.
2. PARITY_MODE 1; send 0xA3 with parity bit 1 (wrong, 0xA3 has four ones) -> m_data = 0xA3, m_parity_err = 1. Resend with parity bit 0 -> m_parity_err = 0.
3. STOP_BITS 2; send 0x3C with the second stop bit driven 0 -> m_data = 0x3C, m_frame_err = 1. Both stop bits 1 -> m_frame_err = 0.
4. rx low for 3 cycles in IDLE, then high -> FSM returns to IDLE, m_valid never asserts. Then a 1-cycle low glitch at c_clocks = HALF inside data bit 2 of 0xFF -> m_data = 0xFF.
5. m_ready held 0; send 0x11 then 0x22 back-to-back -> m_data stays 0x11, one m_overrun pulse at the 0x22 commit. Raise m_ready -> 0x11 accepted, m_valid drops.
6. Assert rstn low during data bit 4 of 0x99, release, send 0x42 -> no output for 0x99, then m_data = 0x42 with no error flags.
